// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the keyboard event scheduler.
//   state_t      - fetch FSM encoding (IDLE, SETTLE, CAPTURE, POP)
//   ASCII_NONE   - lookup value meaning "no printable character"
//   HOLDOFF_DEF  - default interrupt hold-off in clk cycles
package kb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_POP     = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_NONE  = 8'h00;
  localparam int         HOLDOFF_DEF = 3000;

endpackage

// File: rtl/kb_char_fifo.sv
// kb_char_fifo: DEPTH x 8 circular character queue.
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write request and character
//   pop        - read request (ignored when empty)
//   head_data  - registered head character, ASCII_NONE when empty
//   full/empty - occupancy flags, count - number of entries
// A push while full only succeeds if a pop frees the slot in the same cycle.
module kb_char_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  head_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head, tail, head_nxt;
  logic [AW:0]   count_nxt;
  logic [7:0]    data_nxt;
  logic          pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // head_data is registered, so look ahead to what the head will be after
  // this cycle. If the new head is the slot being written right now, the
  // memory does not hold it yet and the incoming character is forwarded.
  always_comb begin
    head_nxt  = pop_ok ? head + AW'(1) : head;
    count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (count_nxt == '0)
      data_nxt = ASCII_NONE;
    else if (push_ok && head_nxt == tail)
      data_nxt = din;
    else
      data_nxt = mem[head_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      head_data <= ASCII_NONE;
    end else begin
      if (push_ok) begin
        mem[tail] <= din;
        tail      <= tail + AW'(1);
      end
      head      <= head_nxt;
      count     <= count_nxt;
      head_data <= data_nxt;
    end
  end

endmodule

// File: rtl/kb_event_sched.sv
// kb_event_sched: drains the kb_code scan buffer one code at a time, keeps
// codes whose ASCII lookup is non-zero in a character queue, and raises a
// level interrupt once the queue has been non-empty for HOLDOFF cycles.
//   clk, Reset          - clock, synchronous active-high reset
//   kb_buf_empty        - scan buffer empty flag from kb_code
//   ascii_code          - lookup result for the current head scan code
//   rd_key_code         - one-cycle pop strobe back to kb_code
//   cpu_rd, cpu_clr     - processor pop pulse, overflow clear
//   cpu_data, q_count   - queue head character and occupancy
//   overflow            - sticky: a valid character was dropped
//   interrupt           - level interrupt to the processor
module kb_event_sched
  import kb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int CW      = 13
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     kb_buf_empty,
  input  logic [7:0]               ascii_code,
  output logic                     rd_key_code,
  input  logic                     cpu_rd,
  input  logic                     cpu_clr,
  output logic [7:0]               cpu_data,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow,
  output logic                     interrupt
);

  state_t        state, state_nxt;
  logic [CW-1:0] hold;
  logic          push, ovf_set, q_full, q_empty;

  // Fetch sequencing. SETTLE gives the external lookup a cycle to follow the
  // new head scan code before CAPTURE samples it.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unique case (state)
      ST_IDLE:    if (!kb_buf_empty) state_nxt = ST_SETTLE;
      ST_SETTLE:  state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        state_nxt = ST_POP;
        if (ascii_code != ASCII_NONE) begin
          push = 1'b1;
          // A coincident processor read frees the slot, so no drop then.
          ovf_set = q_full && !cpu_rd;
        end
      end
      ST_POP:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      rd_key_code <= 1'b0;
      overflow    <= 1'b0;
      hold        <= '0;
    end else begin
      state       <= state_nxt;
      // Registered strobe that coincides with the POP state.
      rd_key_code <= (state_nxt == ST_POP);
      // Set has priority over clear.
      overflow    <= ovf_set | (overflow & ~cpu_clr);
      if (q_empty)
        hold <= '0;
      else if (hold != CW'(HOLDOFF))
        hold <= hold + CW'(1);
    end
  end

  // Decoded from flops only; drops in the same cycle q_count reaches zero.
  assign interrupt = (hold == CW'(HOLDOFF)) && !q_empty;

  kb_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (Reset),
    .push      (push),
    .din       (ascii_code),
    .pop       (cpu_rd),
    .head_data (cpu_data),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_kb_event_sched.sv
// Bench for kb_event_sched: an emulated kb_code scan buffer feeds codes, a
// queue-based reference model predicts every output each cycle, and a set
// of directed scenarios pins the model with literal expectations.
module tb_kb_event_sched;

  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 8;
  localparam int CW      = 5;
  localparam int QW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          kb_buf_empty = 1'b1;
  logic [7:0]    ascii_code = 8'h00;
  logic          cpu_rd = 1'b0;
  logic          cpu_clr = 1'b0;
  logic          rd_key_code, overflow, interrupt;
  logic [7:0]    cpu_data;
  logic [QW-1:0] q_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kb_event_sched #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .CW(CW)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .kb_buf_empty (kb_buf_empty),
    .ascii_code   (ascii_code),
    .rd_key_code  (rd_key_code),
    .cpu_rd       (cpu_rd),
    .cpu_clr      (cpu_clr),
    .cpu_data     (cpu_data),
    .q_count      (q_count),
    .overflow     (overflow),
    .interrupt    (interrupt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- emulated kb_code scan buffer ----------------
  logic [7:0] pending [$];
  int         rd_pulses = 0;

  always @(posedge clk) begin
    if (rd_key_code) begin
      rd_pulses++;
      if (pending.size() > 0) void'(pending.pop_front());
    end
  end

  function automatic void drive_kb();
    kb_buf_empty = (pending.size() == 0);
    ascii_code   = (pending.size() > 0) ? pending[0] : 8'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drive_kb();
  endtask

  // ---------------- reference model ----------------
  // fetch_age: cycles since the current scan code was noticed (0 = waiting).
  // The character is judged at age 2 and the buffer popped at age 3.
  logic [7:0] mq [$];
  int         fetch_age = 0;
  int         m_hold = 0;
  logic       m_ovf = 1'b0;
  logic       m_started = 1'b0;

  always @(posedge clk) begin
    if (Reset) begin
      mq.delete();
      fetch_age = 0;
      m_hold    = 0;
      m_ovf     = 1'b0;
      m_started = 1'b1;
    end else begin
      logic dropped;
      dropped = 1'b0;
      if (mq.size() == 0) m_hold = 0;
      else if (m_hold < HOLDOFF) m_hold = m_hold + 1;
      // Read first so a full queue has room for a same-cycle character.
      if (cpu_rd && mq.size() > 0) void'(mq.pop_front());
      if (fetch_age == 2 && ascii_code != 8'h00) begin
        if (mq.size() < DEPTH) mq.push_back(ascii_code);
        else dropped = 1'b1;
      end
      if (cpu_clr) m_ovf = 1'b0;
      if (dropped) m_ovf = 1'b1;
      if (fetch_age == 0) fetch_age = kb_buf_empty ? 0 : 1;
      else if (fetch_age == 3) fetch_age = 0;
      else fetch_age = fetch_age + 1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("q_count", 32'(q_count), 32'(mq.size()));
      check("cpu_data", 32'(cpu_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("interrupt", 32'(interrupt), 32'(m_hold == HOLDOFF && mq.size() > 0));
      check("rd_key_code", 32'(rd_key_code), 32'(fetch_age == 3));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((pending.size() != 0 || fetch_age != 0) && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(n < max), 32'h1);
  endtask

  task automatic pop_once();
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, r0;
    drive_kb();
    tick();
    tick();
    Reset = 1'b0;

    // Reset values
    check("rst_q_count", 32'(q_count), 32'h0);
    check("rst_cpu_data", 32'(cpu_data), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_interrupt", 32'(interrupt), 32'h0);
    check("rst_rd_key_code", 32'(rd_key_code), 32'h0);

    // One valid character, interrupt after exactly HOLDOFF cycles
    r0 = rd_pulses;
    pending.push_back(8'h41);
    drive_kb();
    n = 0;
    while (q_count != QW'(1) && n < 20) begin tick(); n++; end
    check("t1_push_wait", 32'(n < 20), 32'h1);
    n = 0;
    while (!interrupt && n < HOLDOFF + 5) begin tick(); n++; end
    check("t1_int_delay", 32'(n), 32'(HOLDOFF));
    check("t1_q_count", 32'(q_count), 32'h1);
    check("t1_cpu_data", 32'(cpu_data), 32'h41);
    check("t1_rd_pulses", 32'(rd_pulses - r0), 32'h1);
    pop_once();
    check("t1_pop_q_count", 32'(q_count), 32'h0);
    check("t1_pop_interrupt", 32'(interrupt), 32'h0);
    check("t1_pop_cpu_data", 32'(cpu_data), 32'h0);

    // Unmapped scan code is consumed and discarded
    r0 = rd_pulses;
    pending.push_back(8'h00);
    drive_kb();
    wait_idle("t2_wait", 30);
    tick();
    check("t2_rd_pulses", 32'(rd_pulses - r0), 32'h1);
    check("t2_q_count", 32'(q_count), 32'h0);
    check("t2_interrupt", 32'(interrupt), 32'h0);

    // Five characters into a 4-deep queue
    for (int i = 0; i < 5; i++) pending.push_back(8'h31 + 8'(i));
    drive_kb();
    wait_idle("t3_wait", 60);
    check("t3_q_count", 32'(q_count), 32'h4);
    check("t3_overflow", 32'(overflow), 32'h1);
    repeat (HOLDOFF + 2) tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_cpu_data", 32'(cpu_data), 32'h31 + 32'(i));
      check("t3_int_held", 32'(interrupt), 32'h1);
      pop_once();
    end
    check("t3_empty_q_count", 32'(q_count), 32'h0);
    check("t3_int_fall", 32'(interrupt), 32'h0);
    check("t3_ovf_sticky", 32'(overflow), 32'h1);
    cpu_clr = 1'b1;
    tick();
    cpu_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'h0);

    // Full queue, read coincident with capture of 8'h5A
    for (int i = 0; i < 4; i++) pending.push_back(8'h61 + 8'(i));
    drive_kb();
    wait_idle("t4_fill_wait", 60);
    check("t4_full", 32'(q_count), 32'h4);
    pending.push_back(8'h5A);
    drive_kb();
    n = 0;
    while (fetch_age != 2 && n < 20) begin tick(); n++; end
    check("t4_capture_wait", 32'(n < 20), 32'h1);
    pop_once();
    wait_idle("t4_wait", 20);
    check("t4_q_count", 32'(q_count), 32'h4);
    check("t4_overflow", 32'(overflow), 32'h0);
    check("t4_data0", 32'(cpu_data), 32'h62); pop_once();
    check("t4_data1", 32'(cpu_data), 32'h63); pop_once();
    check("t4_data2", 32'(cpu_data), 32'h64); pop_once();
    check("t4_data3", 32'(cpu_data), 32'h5A); pop_once();
    check("t4_drained", 32'(q_count), 32'h0);

    // Read from an empty queue
    pop_once();
    check("t5_q_count", 32'(q_count), 32'h0);
    check("t5_cpu_data", 32'(cpu_data), 32'h0);
    check("t5_interrupt", 32'(interrupt), 32'h0);

    // Reset during SETTLE abandons the fetch, then a fresh fetch completes
    pending.push_back(8'h77);
    drive_kb();
    n = 0;
    while (fetch_age != 1 && n < 20) begin tick(); n++; end
    check("t6_settle_wait", 32'(n < 20), 32'h1);
    r0 = rd_pulses;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_rst_rd", 32'(rd_key_code), 32'h0);
    check("t6_rst_q_count", 32'(q_count), 32'h0);
    check("t6_rst_interrupt", 32'(interrupt), 32'h0);
    check("t6_rst_pending", 32'(pending.size()), 32'h1);
    wait_idle("t6_wait", 30);
    check("t6_rd_pulses", 32'(rd_pulses - r0), 32'h1);
    check("t6_q_count", 32'(q_count), 32'h1);
    check("t6_cpu_data", 32'(cpu_data), 32'h77);
    pop_once();

    // Randomized traffic; alternate slow and fast readers to reach both
    // overflow and drain conditions
    for (int i = 0; i < 1200; i++) begin
      int rd_pct;
      rd_pct = ((i / 150) % 2 == 1) ? 5 : 40;
      if (pending.size() < 3 && $urandom_range(0, 2) == 0)
        pending.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      drive_kb();
      cpu_rd  = ($urandom_range(0, 99) < rd_pct);
      cpu_clr = ($urandom_range(0, 99) < 4);
      Reset   = ($urandom_range(0, 399) == 0);
      tick();
    end
    cpu_rd  = 1'b0;
    cpu_clr = 1'b0;
    Reset   = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
